// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared constants and state encoding for the convolution sequencer
package conv_pkg;

   localparam int BIT_DEPTH = 16;
   localparam int N_W       = 14;
   localparam int ADDR_W    = 5;
   localparam int RD_LAT    = 2;
   localparam int DP_LAT    = 3;
   localparam int FRAME_PIX = 676;
   localparam int CNT_W     = 10;

   // Park address sits above the 2*N_W weight words so it never aliases a fetch.
   localparam logic [ADDR_W-1:0] PARK_ADDR = '1;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_WFETCH = 3'd1;
   localparam logic [2:0] S_WDRAIN = 3'd2;
   localparam logic [2:0] S_RUN    = 3'd3;
   localparam logic [2:0] S_FLUSH  = 3'd4;
   localparam logic [2:0] S_DONE   = 3'd5;

endpackage

// File: rtl/valid_delay.sv
// rtl/valid_delay.sv - 1-bit strobe delay line with synchronous active-low clear
module valid_delay #(
   parameter int DEPTH = 2
) (
   input  logic clk,
   input  logic RESET,
   input  logic din,
   output logic dout
);

   logic [DEPTH-1:0] line;

   always_ff @(posedge clk) begin
      if (!RESET)
         line <= '0;
      else
         line <= {line[DEPTH-2:0], din};
   end

   assign dout = line[DEPTH-1];

endmodule

// File: rtl/conv_sched.sv
// rtl/conv_sched.sv - weight fetch and frame streaming sequencer for the 3x3 convolution datapath
module conv_sched
   import conv_pkg::*;
(
   input  logic              clk,
   input  logic              RESET,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              w_valid,
   output logic [ADDR_W-1:0] bram_addr_a,
   output logic [ADDR_W-1:0] bram_addr_b,
   output logic              bram_rden_a,
   output logic              bram_rden_b,
   output logic              w_shift_en,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              out_valid,
   output logic [CNT_W-1:0]  in_cnt,
   output logic [CNT_W-1:0]  out_cnt
);

   localparam logic [CNT_W-1:0]  FRAME_CNT = CNT_W'(FRAME_PIX);
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
   localparam logic [ADDR_W-1:0] LAST_K    = ADDR_W'(N_W - 1);
   localparam logic [ADDR_W-1:0] B_OFS     = ADDR_W'(N_W);
   localparam logic [ADDR_W-1:0] A_ONE     = ADDR_W'(1);

   logic [2:0]        state;
   logic [ADDR_W-1:0] k;
   logic              xfer;

   assign busy     = (state != S_IDLE);
   assign done     = (state == S_DONE);
   assign in_ready = (state == S_RUN) && (in_cnt < FRAME_CNT);
   assign xfer     = in_valid & in_ready;

   valid_delay #(.DEPTH(RD_LAT)) u_rd_dly (
      .clk   (clk),
      .RESET (RESET),
      .din   (bram_rden_a),
      .dout  (w_shift_en)
   );

   valid_delay #(.DEPTH(DP_LAT)) u_dp_dly (
      .clk   (clk),
      .RESET (RESET),
      .din   (xfer),
      .dout  (out_valid)
   );

   always_ff @(posedge clk) begin
      if (!RESET) begin
         state       <= S_IDLE;
         k           <= '0;
         bram_addr_a <= PARK_ADDR;
         bram_addr_b <= PARK_ADDR;
         bram_rden_a <= 1'b0;
         bram_rden_b <= 1'b0;
         w_valid     <= 1'b0;
         in_cnt      <= '0;
         out_cnt     <= '0;
      end else begin
         if (xfer)
            in_cnt <= in_cnt + CNT_ONE;
         if (out_valid && (out_cnt < FRAME_CNT))
            out_cnt <= out_cnt + CNT_ONE;

         case (state)
            S_IDLE: begin
               if (start) begin
                  state       <= S_WFETCH;
                  k           <= '0;
                  bram_addr_a <= '0;
                  bram_addr_b <= B_OFS;
                  bram_rden_a <= 1'b1;
                  bram_rden_b <= 1'b1;
                  w_valid     <= 1'b0;
                  in_cnt      <= '0;
                  out_cnt     <= '0;
               end
            end
            S_WFETCH: begin
               if (k == LAST_K) begin
                  state       <= S_WDRAIN;
                  bram_addr_a <= PARK_ADDR;
                  bram_addr_b <= PARK_ADDR;
                  bram_rden_a <= 1'b0;
                  bram_rden_b <= 1'b0;
               end else begin
                  k           <= k + A_ONE;
                  bram_addr_a <= k + A_ONE;
                  bram_addr_b <= k + A_ONE + B_OFS;
               end
            end
            // Shift pulses are contiguous, so the first low cycle means the line has emptied.
            S_WDRAIN: begin
               if (!w_shift_en) begin
                  state   <= S_RUN;
                  w_valid <= 1'b1;
               end
            end
            S_RUN: begin
               if (xfer && (in_cnt == FRAME_CNT - CNT_ONE))
                  state <= S_FLUSH;
            end
            S_FLUSH: begin
               if (out_valid && (out_cnt == FRAME_CNT - CNT_ONE))
                  state <= S_DONE;
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_conv_sched.sv
// tb/tb_conv_sched.sv - directed self-checking bench for conv_sched
module tb_conv_sched;
   import conv_pkg::*;

   logic              clk = 1'b0;
   logic              RESET;
   logic              start;
   logic              busy;
   logic              done;
   logic              w_valid;
   logic [ADDR_W-1:0] bram_addr_a;
   logic [ADDR_W-1:0] bram_addr_b;
   logic              bram_rden_a;
   logic              bram_rden_b;
   logic              w_shift_en;
   logic              in_valid;
   logic              in_ready;
   logic              out_valid;
   logic [CNT_W-1:0]  in_cnt;
   logic [CNT_W-1:0]  out_cnt;

   int n_vec = 0;
   int n_err = 0;

   logic [15:0] qa1, qa, qb1, qb;
   logic [15:0] chain_a [0:13];
   logic [15:0] chain_b [0:13];

   conv_sched dut (
      .clk         (clk),
      .RESET       (RESET),
      .start       (start),
      .busy        (busy),
      .done        (done),
      .w_valid     (w_valid),
      .bram_addr_a (bram_addr_a),
      .bram_addr_b (bram_addr_b),
      .bram_rden_a (bram_rden_a),
      .bram_rden_b (bram_rden_b),
      .w_shift_en  (w_shift_en),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .out_valid   (out_valid),
      .in_cnt      (in_cnt),
      .out_cnt     (out_cnt)
   );

   always #5 clk = ~clk;

   // BRAM holding 100+address, two-cycle read latency, feeding two 14-deep shift chains.
   always @(posedge clk) begin
      qa1 <= bram_rden_a ? 16'(100 + 32'(bram_addr_a)) : 16'hdead;
      qb1 <= bram_rden_b ? 16'(100 + 32'(bram_addr_b)) : 16'hdead;
      qa  <= qa1;
      qb  <= qb1;
      if (w_shift_en) begin
         chain_a[0] <= qa;
         chain_b[0] <= qb;
         for (int i = 1; i < 14; i++) begin
            chain_a[i] <= chain_a[i-1];
            chain_b[i] <= chain_b[i-1];
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic do_fetch();
      int first_sh;
      int last_sh;
      int n_sh;
      int rise;
      start    = 1'b1;
      in_valid = 1'b1;
      tick();
      start = 1'b0;
      check("fetch_wvalid_clear", 32'(w_valid), 32'd0);
      first_sh = -1;
      last_sh  = -1;
      n_sh     = 0;
      rise     = -1;
      for (int c = 0; c < 24 && rise < 0; c++) begin
         if (c < 14) begin
            check("fetch_addr_a", 32'(bram_addr_a), 32'(c));
            check("fetch_addr_b", 32'(bram_addr_b), 32'(c + 14));
            check("fetch_rden_a", 32'(bram_rden_a), 32'd1);
            check("fetch_rden_b", 32'(bram_rden_b), 32'd1);
            check("fetch_in_ready", 32'(in_ready), 32'd0);
         end else if (c == 14) begin
            check("drain_addr_a_park", 32'(bram_addr_a), 32'd31);
            check("drain_addr_b_park", 32'(bram_addr_b), 32'd31);
            check("drain_rden_a", 32'(bram_rden_a), 32'd0);
         end
         if (w_shift_en) begin
            if (first_sh < 0) first_sh = c;
            last_sh = c;
            n_sh++;
         end
         if (w_valid) rise = c;
         else tick();
      end
      check("fetch_in_valid_ignored", 32'(in_cnt), 32'd0);
      check("shift_first_cycle", 32'(first_sh), 32'd2);
      check("shift_pulse_count", 32'(n_sh), 32'd14);
      check("shift_last_cycle", 32'(last_sh), 32'd15);
      check("wvalid_after_shift", 32'(rise > last_sh && rise <= last_sh + 3), 32'd1);
      check("chain_a_newest", 32'(chain_a[0]), 32'd113);
      check("chain_a_oldest", 32'(chain_a[13]), 32'd100);
      check("chain_b_newest", 32'(chain_b[0]), 32'd127);
      check("chain_b_oldest", 32'(chain_b[13]), 32'd114);
   endtask

   // mode 0: in_valid held high; mode 1: 1,0,0,1 repeating. abort_at >= 0 resets at that in_cnt.
   task automatic run_frame(input int mode, input int abort_at);
      int  mcnt;
      int  ocnt;
      bit  fin;
      bit  iv;
      bit  exp_ready;
      bit  exp_o;
      bit  xh [0:2047];
      mcnt = 0;
      ocnt = 0;
      fin  = 1'b0;
      for (int t = 0; t < 1600 && !fin; t++) begin
         iv = (mode == 0) ? 1'b1 : ((t % 4 == 0) || (t % 4 == 3));
         in_valid  = iv;
         exp_ready = (mcnt < FRAME_PIX);
         xh[t]     = iv && exp_ready;
         exp_o     = (t >= 3) ? xh[t-3] : 1'b0;
         check("run_in_cnt", 32'(in_cnt), 32'(mcnt));
         check("run_out_cnt", 32'(out_cnt), 32'(ocnt));
         if (abort_at >= 0 && mcnt == abort_at) begin
            RESET    = 1'b0;
            in_valid = 1'b1;
            tick();
            RESET = 1'b1;
            check("abort_busy", 32'(busy), 32'd0);
            check("abort_wvalid", 32'(w_valid), 32'd0);
            check("abort_in_cnt", 32'(in_cnt), 32'd0);
            check("abort_out_cnt", 32'(out_cnt), 32'd0);
            for (int j = 0; j < 6; j++) begin
               check("abort_out_valid", 32'(out_valid), 32'd0);
               check("abort_in_cnt_hold", 32'(in_cnt), 32'd0);
               tick();
            end
            in_valid = 1'b0;
            fin = 1'b1;
         end else begin
            check("run_in_ready", 32'(in_ready), 32'(exp_ready));
            check("run_out_valid", 32'(out_valid), 32'(exp_o));
            check("run_done", 32'(done), 32'(ocnt == FRAME_PIX));
            check("run_busy", 32'(busy), 32'd1);
            check("run_wvalid", 32'(w_valid), 32'd1);
            start = (t == 100);
            if (ocnt == FRAME_PIX) begin
               start = 1'b1;
               tick();
               start    = 1'b0;
               in_valid = 1'b0;
               check("post_done_busy", 32'(busy), 32'd0);
               check("post_done_done", 32'(done), 32'd0);
               check("post_done_no_restart", 32'(bram_rden_a), 32'd0);
               check("post_done_wvalid", 32'(w_valid), 32'd1);
               check("post_done_in_cnt", 32'(in_cnt), 32'd676);
               check("post_done_out_cnt", 32'(out_cnt), 32'd676);
               fin = 1'b1;
            end else begin
               mcnt += int'(xh[t]);
               ocnt += int'(exp_o);
               tick();
            end
         end
      end
      start = 1'b0;
      if (!fin) check("frame_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      RESET    = 1'b0;
      start    = 1'b1;
      in_valid = 1'b1;
      repeat (3) tick();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_wvalid", 32'(w_valid), 32'd0);
      check("rst_rden_a", 32'(bram_rden_a), 32'd0);
      check("rst_rden_b", 32'(bram_rden_b), 32'd0);
      check("rst_shift", 32'(w_shift_en), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_addr_a", 32'(bram_addr_a), 32'd31);
      check("rst_addr_b", 32'(bram_addr_b), 32'd31);
      check("rst_in_cnt", 32'(in_cnt), 32'd0);
      check("rst_out_cnt", 32'(out_cnt), 32'd0);

      RESET = 1'b1;
      start = 1'b0;
      tick();
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_in_cnt", 32'(in_cnt), 32'd0);

      do_fetch();
      run_frame(0, -1);
      repeat (3) tick();
      check("idle_wvalid_hold", 32'(w_valid), 32'd1);
      check("idle_in_cnt_hold", 32'(in_cnt), 32'd676);

      do_fetch();
      run_frame(1, -1);

      do_fetch();
      run_frame(0, 300);
      do_fetch();
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
